// File: rtl/rxframe_parser.sv
// rxframe_parser -- byte-stream frame parser for a sensor bus node.
//
// Frame: HEAD1 HEAD2 LEN_H LEN_L DEV_ID SID RW data[0..LEN-4] CHK_H CHK_L
//   LEN counts DEV_ID through the last data byte; CHK is the 16-bit sum of
//   LEN_H through the last data byte.
//
// Ports:
//   sys_clk      in   clock, rising edge
//   sys_rst      in   asynchronous reset, active-low
//   rx_flag      in   one-cycle strobe, rx_data valid
//   rx_data      in   [7:0] received byte
//   ret_cmd      out  [3:0] response code (0 ACK, 1 CRC, 2 LEN, 3 SID error)
//   ret_cmd_flg  out  one-cycle strobe, ret_cmd valid
//   sen_sel      out  [N_SEN-1:0] one-hot target sensor
//   sen_rw       out  1 = write, 0 = read
//   sen_len      out  [3:0] payload byte count
//   sen_data     out  [8*MAX_DATA-1:0] payload, first byte in [7:0]
//   sen_cmd_vld  out  one-cycle strobe, sen_* valid
module rxframe_parser #(
  parameter logic [7:0] HEAD1       = 8'hAA,
  parameter logic [7:0] HEAD2       = 8'h55,
  parameter logic [7:0] MY_ID       = 8'h01,
  parameter int         N_SEN       = 4,
  parameter int         MAX_DATA    = 4,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  rx_flag,
  input  logic [7:0]            rx_data,
  output logic [3:0]            ret_cmd,
  output logic                  ret_cmd_flg,
  output logic [N_SEN-1:0]      sen_sel,
  output logic                  sen_rw,
  output logic [3:0]            sen_len,
  output logic [8*MAX_DATA-1:0] sen_data,
  output logic                  sen_cmd_vld
);

  typedef enum logic [3:0] {
    S_WAIT, S_HEAD2, S_LEN_H, S_LEN_L, S_DEV, S_SID, S_RW,
    S_DATA, S_CHK_H, S_CHK_L, S_SKIP
  } state_t;

  localparam logic [3:0]  ACK_OK  = 4'h0;
  localparam logic [3:0]  ERR_CRC = 4'h1;
  localparam logic [3:0]  ERR_LEN = 4'h2;
  localparam logic [3:0]  ERR_SID = 4'h3;
  localparam logic [15:0] LEN_MAX = 16'(MAX_DATA + 3);
  localparam logic [7:0]  N_SEN_B = 8'(N_SEN);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t                state;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [15:0]           chk;
  logic [7:0]            chk_hi;
  logic [16:0]           skip_cnt;
  logic                  skip_err;
  logic                  bcast;
  logic [7:0]            sid;
  logic                  rw;
  logic [3:0]            plen;
  logic [3:0]            cnt;
  logic [8*MAX_DATA-1:0] dbuf;
  logic [31:0]           tcnt;

  logic [15:0]           len_full;
  logic [15:0]           chk_add;
  logic                  timeout;
  logic [8*MAX_DATA-1:0] data_masked;

  assign len_full = {len_hi, rx_data};
  assign chk_add  = chk + {8'h00, rx_data};
  assign timeout  = (state != S_WAIT) && !rx_flag && (tcnt == TO_LAST);

  // Payload buffer keeps stale bytes from longer earlier frames; zero them.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < MAX_DATA; i++) begin
      if (i < int'(plen)) data_masked[8*i +: 8] = dbuf[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= S_WAIT;
      len_hi      <= '0;
      len         <= '0;
      chk         <= '0;
      chk_hi      <= '0;
      skip_cnt    <= '0;
      skip_err    <= 1'b0;
      bcast       <= 1'b0;
      sid         <= '0;
      rw          <= 1'b0;
      plen        <= '0;
      cnt         <= '0;
      dbuf        <= '0;
      tcnt        <= '0;
      ret_cmd     <= '0;
      ret_cmd_flg <= 1'b0;
      sen_sel     <= '0;
      sen_rw      <= 1'b0;
      sen_len     <= '0;
      sen_data    <= '0;
      sen_cmd_vld <= 1'b0;
    end else begin
      ret_cmd_flg <= 1'b0;
      sen_cmd_vld <= 1'b0;

      if (rx_flag || state == S_WAIT) tcnt <= '0;
      else                            tcnt <= tcnt + 32'd1;

      if (rx_flag) begin
        case (state)
          S_WAIT:  if (rx_data == HEAD1) state <= S_HEAD2;
          S_HEAD2: begin
            if (rx_data == HEAD2)      state <= S_LEN_H;
            else if (rx_data == HEAD1) state <= S_HEAD2;
            else                       state <= S_WAIT;
          end
          S_LEN_H: begin
            len_hi <= rx_data;
            chk    <= {8'h00, rx_data};
            state  <= S_LEN_L;
          end
          S_LEN_L: begin
            len  <= len_full;
            chk  <= chk_add;
            plen <= 4'(len_full - 16'd3);
            if (len_full < 16'd4 || len_full > LEN_MAX) begin
              // Bad length: swallow the rest of the frame plus checksum.
              skip_cnt <= {1'b0, len_full} + 17'd2;
              skip_err <= 1'b1;
              state    <= S_SKIP;
            end else begin
              state <= S_DEV;
            end
          end
          S_DEV: begin
            chk   <= chk_add;
            bcast <= (rx_data == 8'hFF);
            if (rx_data == MY_ID || rx_data == 8'hFF) begin
              state <= S_SID;
            end else begin
              // Frame for another node: skip silently.
              skip_cnt <= {1'b0, len} + 17'd1;
              skip_err <= 1'b0;
              state    <= S_SKIP;
            end
          end
          S_SID: begin
            chk   <= chk_add;
            sid   <= rx_data;
            state <= S_RW;
          end
          S_RW: begin
            chk   <= chk_add;
            rw    <= rx_data[0];
            cnt   <= '0;
            state <= S_DATA;
          end
          S_DATA: begin
            chk                     <= chk_add;
            dbuf[8*int'(cnt) +: 8]  <= rx_data;
            cnt                     <= cnt + 4'd1;
            if (cnt == plen - 4'd1) state <= S_CHK_H;
          end
          S_CHK_H: begin
            chk_hi <= rx_data;
            state  <= S_CHK_L;
          end
          S_CHK_L: begin
            state <= S_WAIT;
            // Broadcast frames never answer on ret_cmd.
            if ({chk_hi, rx_data} != chk) begin
              if (!bcast) begin
                ret_cmd     <= ERR_CRC;
                ret_cmd_flg <= 1'b1;
              end
            end else if (sid >= N_SEN_B) begin
              if (!bcast) begin
                ret_cmd     <= ERR_SID;
                ret_cmd_flg <= 1'b1;
              end
            end else begin
              sen_cmd_vld <= 1'b1;
              sen_sel     <= N_SEN'(1) << sid;
              sen_rw      <= rw;
              sen_len     <= plen;
              sen_data    <= data_masked;
              if (!bcast) begin
                ret_cmd     <= ACK_OK;
                ret_cmd_flg <= 1'b1;
              end
            end
          end
          S_SKIP: begin
            skip_cnt <= skip_cnt - 17'd1;
            if (skip_cnt == 17'd1) begin
              state <= S_WAIT;
              if (skip_err) begin
                ret_cmd     <= ERR_LEN;
                ret_cmd_flg <= 1'b1;
              end
            end
          end
          default: state <= S_WAIT;
        endcase
      end else if (timeout) begin
        state <= S_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_rxframe_parser.sv
module tb_rxframe_parser;

  localparam int TO = 100;

  logic        sys_clk;
  logic        sys_rst;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic [3:0]  ret_cmd;
  logic        ret_cmd_flg;
  logic [3:0]  sen_sel;
  logic        sen_rw;
  logic [3:0]  sen_len;
  logic [31:0] sen_data;
  logic        sen_cmd_vld;

  rxframe_parser #(
    .HEAD1(8'hAA), .HEAD2(8'h55), .MY_ID(8'h01),
    .N_SEN(4), .MAX_DATA(4), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_flag(rx_flag), .rx_data(rx_data),
    .ret_cmd(ret_cmd), .ret_cmd_flg(ret_cmd_flg), .sen_sel(sen_sel),
    .sen_rw(sen_rw), .sen_len(sen_len), .sen_data(sen_data),
    .sen_cmd_vld(sen_cmd_vld)
  );

  typedef struct {
    logic        flg;
    logic        vld;
    logic [3:0]  cmd;
    logic [3:0]  sel;
    logic        rw;
    logic [3:0]  len;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] fq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_cyc = 0;

  // Reference model of held output values.
  logic [3:0]  m_cmd = '0;
  logic [3:0]  m_sel = '0;
  logic        m_rw = 1'b0;
  logic [3:0]  m_len = '0;
  logic [31:0] m_data = '0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (ret_cmd_flg || sen_cmd_vld) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe cyc=%0d flg=%b vld=%b cmd=%h, required no strobe",
                 cyc, ret_cmd_flg, sen_cmd_vld, ret_cmd);
      end else begin
        mon_e = sbq.pop_front();
        if ({ret_cmd_flg, sen_cmd_vld, ret_cmd, sen_sel, sen_rw, sen_len, sen_data} !==
            {mon_e.flg, mon_e.vld, mon_e.cmd, mon_e.sel, mon_e.rw, mon_e.len, mon_e.data} ||
            cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL strobe cyc=%0d flg=%b vld=%b cmd=%h sel=%b rw=%b len=%0d data=%h, required cyc=%0d flg=%b vld=%b cmd=%h sel=%b rw=%b len=%0d data=%h",
                   cyc, ret_cmd_flg, sen_cmd_vld, ret_cmd, sen_sel, sen_rw, sen_len, sen_data,
                   mon_e.cyc, mon_e.flg, mon_e.vld, mon_e.cmd, mon_e.sel, mon_e.rw, mon_e.len, mon_e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_flag = 1'b1;
    rx_data = b;
    @(posedge sys_clk);
    #1;
    rx_flag  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_q(input int gap);
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (gap > 0 && i != fq.size() - 1) idle($urandom_range(0, gap));
    end
  endtask

  task automatic push_exp(input logic flg, input logic vld);
    exp_t x;
    x.flg = flg; x.vld = vld; x.cmd = m_cmd; x.sel = m_sel; x.rw = m_rw;
    x.len = m_len; x.data = m_data; x.cyc = last_cyc;
    sbq.push_back(x);
  endtask

  task automatic load_bytes(input logic [7:0] b[], input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(b[i]);
  endtask

  task automatic build_frame(input logic [7:0] dev, input logic [7:0] sid,
                             input logic [7:0] rwb, input int n,
                             input logic [31:0] d, input bit corrupt);
    logic [15:0] len, sum;
    len = 16'(n + 3);
    sum = {8'h00, len[15:8]} + {8'h00, len[7:0]} + {8'h00, dev} + {8'h00, sid} + {8'h00, rwb};
    fq.delete();
    fq.push_back(8'hAA); fq.push_back(8'h55);
    fq.push_back(len[15:8]); fq.push_back(len[7:0]);
    fq.push_back(dev); fq.push_back(sid); fq.push_back(rwb);
    for (int i = 0; i < n; i++) begin
      fq.push_back(d[8*i +: 8]);
      sum = sum + {8'h00, d[8*i +: 8]};
    end
    if (corrupt) sum = sum ^ 16'h0001;
    fq.push_back(sum[15:8]); fq.push_back(sum[7:0]);
  endtask

  task automatic expect_frame(input logic [7:0] dev, input logic [7:0] sid,
                              input logic [7:0] rwb, input int n,
                              input logic [31:0] d, input bit corrupt);
    bit bc;
    bc = (dev == 8'hFF);
    if (dev == 8'h01 || bc) begin
      if (corrupt || sid >= 8'd4) begin
        if (!bc) begin
          m_cmd = corrupt ? 4'h1 : 4'h3;
          push_exp(1'b1, 1'b0);
        end
      end else begin
        m_sel  = 4'b0001 << sid;
        m_rw   = rwb[0];
        m_len  = 4'(n);
        m_data = '0;
        for (int i = 0; i < n; i++) m_data[8*i +: 8] = d[8*i +: 8];
        if (!bc) m_cmd = 4'h0;
        push_exp(!bc, 1'b1);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] dev, input logic [7:0] sid,
                           input logic [7:0] rwb, input int n,
                           input logic [31:0] d, input bit corrupt, input int gap);
    build_frame(dev, sid, rwb, n, d, corrupt);
    send_q(gap);
    expect_frame(dev, sid, rwb, n, d, corrupt);
  endtask

  task automatic drain(input string name);
    idle(4);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_strobe pending=%0d, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    idle(3);
    n_chk++;
    if ({ret_cmd, ret_cmd_flg, sen_sel, sen_rw, sen_len, sen_data, sen_cmd_vld} !== 46'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got cmd=%h flg=%b sel=%b rw=%b len=%h data=%h vld=%b, required all 0",
               ret_cmd, ret_cmd_flg, sen_sel, sen_rw, sen_len, sen_data, sen_cmd_vld);
    end
    sys_rst = 1'b1;
    idle(2);
    n_chk++;
    if ({ret_cmd_flg, sen_cmd_vld} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_strobes got %b, required 00", {ret_cmd_flg, sen_cmd_vld});
    end
  endtask

  task automatic test_valid();
    logic [7:0] b[] = '{8'hAA, 8'h55, 8'h00, 8'h05, 8'h01, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'h4F};
    load_bytes(b, 11);
    send_q(0);
    m_cmd = 4'h0; m_sel = 4'b0100; m_rw = 1'b1; m_len = 4'd2; m_data = 32'h00003412;
    push_exp(1'b1, 1'b1);
    drain("valid");
    n_chk++;
    if ({sen_sel, sen_rw, sen_len, sen_data, ret_cmd} !== {4'b0100, 1'b1, 4'd2, 32'h00003412, 4'h0}) begin
      n_fail++;
      $display("FAIL valid_hold got sel=%b rw=%b len=%0d data=%h cmd=%h, required 0100 1 2 00003412 0",
               sen_sel, sen_rw, sen_len, sen_data, ret_cmd);
    end
  endtask

  task automatic test_crc();
    logic [7:0] b[] = '{8'hAA, 8'h55, 8'h00, 8'h05, 8'h01, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'h4E};
    load_bytes(b, 11);
    send_q(0);
    m_cmd = 4'h1;
    push_exp(1'b1, 1'b0);
    drain("crc");
  endtask

  task automatic test_dev_mismatch();
    logic [7:0] b[] = '{8'hAA, 8'h55, 8'h00, 8'h05, 8'h02, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'h50};
    load_bytes(b, 11);
    send_q(0);
    drain("dev_mismatch");
    run_frame(8'h01, 8'h02, 8'h01, 2, 32'h00003412, 1'b0, 0);
    drain("dev_then_valid");
  endtask

  task automatic test_len_err();
    logic [7:0] b[] = '{8'hAA, 8'h55, 8'h00, 8'h09, 8'h01, 8'h00, 8'h01, 8'h11,
                        8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hAA, 8'h55};
    logic [7:0] s[] = '{8'hAA, 8'h55, 8'h00, 8'h03, 8'h01, 8'h00, 8'h01, 8'h00, 8'h05};
    load_bytes(b, 15);
    send_q(0);
    m_cmd = 4'h2;
    push_exp(1'b1, 1'b0);
    drain("len_long");
    load_bytes(s, 9);
    send_q(1);
    push_exp(1'b1, 1'b0);
    drain("len_short");
    run_frame(8'h01, 8'h03, 8'h00, 4, 32'hDEADBEEF, 1'b0, 0);
    drain("len_max");
  endtask

  task automatic test_sid();
    run_frame(8'h01, 8'h04, 8'h01, 1, 32'h000000C3, 1'b0, 0);
    drain("sid_err");
    run_frame(8'h01, 8'h00, 8'h00, 1, 32'h000000C3, 1'b0, 0);
    drain("sid_zero");
  endtask

  task automatic test_broadcast();
    run_frame(8'hFF, 8'h01, 8'h00, 3, 32'h00ABCDEF, 1'b0, 0);
    drain("bcast_valid");
    n_chk++;
    if (ret_cmd !== m_cmd) begin
      n_fail++;
      $display("FAIL bcast_ret_cmd_hold got %h, required %h", ret_cmd, m_cmd);
    end
    run_frame(8'hFF, 8'h01, 8'h00, 3, 32'h00ABCDEF, 1'b1, 0);
    drain("bcast_crc");
  endtask

  task automatic test_timeout();
    logic [7:0] h[] = '{8'hAA, 8'h55, 8'h00, 8'h05, 8'h01, 8'h02};
    logic [7:0] t[] = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h4F};
    load_bytes(h, 5);
    send_q(0);
    idle(TO + 5);
    run_frame(8'h01, 8'h02, 8'h01, 2, 32'h00003412, 1'b0, 0);
    drain("timeout_next");
    // Gap just under the limit keeps the frame alive.
    load_bytes(h, 6);
    send_q(0);
    idle(TO - 2);
    load_bytes(t, 5);
    send_q(0);
    m_cmd = 4'h0; m_sel = 4'b0100; m_rw = 1'b1; m_len = 4'd2; m_data = 32'h00003412;
    push_exp(1'b1, 1'b1);
    drain("timeout_under");
    // Gap over the limit drops it; the tail bytes are then ignored.
    load_bytes(h, 6);
    send_q(0);
    idle(TO + 1);
    load_bytes(t, 5);
    send_q(0);
    drain("timeout_over");
  endtask

  task automatic test_resync();
    build_frame(8'h01, 8'h01, 8'h01, 2, 32'h00007788, 1'b0);
    fq.push_front(8'hAA);
    fq.push_front(8'h12);
    fq.push_front(8'hAA);
    fq.push_front(8'h00);
    send_q(0);
    expect_frame(8'h01, 8'h01, 8'h01, 2, 32'h00007788, 1'b0);
    drain("resync");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h01, 8'h03, 8'h01, 4, 32'h01020304, 1'b0, 0);
    run_frame(8'h01, 8'h01, 8'h00, 1, 32'h000000FE, 1'b0, 0);
    run_frame(8'h01, 8'h02, 8'h01, 3, 32'h00A0B0C0, 1'b1, 0);
    drain("b2b");
    for (int k = 0; k < 10; k++) begin
      logic [7:0] dev;
      int sel;
      sel = $urandom_range(0, 5);
      dev = (sel == 0) ? 8'h02 : (sel == 1) ? 8'hFF : 8'h01;
      run_frame(dev, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 1)),
                $urandom_range(1, 4), $urandom, ($urandom_range(0, 3) == 0), 2);
    end
    drain("random");
  endtask

  task automatic test_reset_mid();
    logic [7:0] h[] = '{8'hAA, 8'h55, 8'h00, 8'h05, 8'h01, 8'h02};
    logic [7:0] t[] = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h4F};
    load_bytes(h, 6);
    send_q(0);
    sys_rst = 1'b0;
    idle(2);
    sys_rst = 1'b1;
    m_cmd = '0; m_sel = '0; m_rw = 1'b0; m_len = '0; m_data = '0;
    load_bytes(t, 5);
    send_q(0);
    drain("reset_mid");
    n_chk++;
    if ({ret_cmd, ret_cmd_flg, sen_sel, sen_rw, sen_len, sen_data, sen_cmd_vld} !== 46'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got cmd=%h sel=%b rw=%b len=%h data=%h, required all 0",
               ret_cmd, sen_sel, sen_rw, sen_len, sen_data);
    end
  endtask

  initial begin
    sys_rst = 1'b0;
    rx_flag = 1'b0;
    rx_data = 8'h00;
    #1;
    test_reset();
    test_valid();
    test_crc();
    test_dev_mismatch();
    test_len_err();
    test_sid();
    test_broadcast();
    test_timeout();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rxframe_parser.md
RXFRAME_PARSER -- requirements
Module: rxframe_parser

Interface
REQ-001 SHALL have parameter HEAD1, default 8'hAA, first frame header byte.
REQ-002 SHALL have parameter HEAD2, default 8'h55, second frame header byte.
REQ-003 SHALL have parameter MY_ID, default 8'h01, this node's bus address.
REQ-004 SHALL have parameter N_SEN, default 4, number of sensor channels (1..8).
REQ-005 SHALL have parameter MAX_DATA, default 4, maximum payload bytes (1..8).
REQ-006 SHALL have parameter TIMEOUT_CYC, default 50000, inter-byte timeout in clocks.
REQ-007 SHALL have port sys_clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port sys_rst, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port rx_flag, input, 1, one-cycle strobe: rx_data valid.
REQ-010 SHALL have port rx_data, input, 8, received byte.
REQ-011 SHALL have port ret_cmd, output, 4, response code to the frame generator.
REQ-012 SHALL have port ret_cmd_flg, output, 1, one-cycle strobe: ret_cmd valid.
REQ-013 SHALL have port sen_sel, output, N_SEN, one-hot target sensor.
REQ-014 SHALL have port sen_rw, output, 1, 1 = write, 0 = read.
REQ-015 SHALL have port sen_len, output, 4, payload byte count.
REQ-016 SHALL have port sen_data, output, 8*MAX_DATA, payload; first byte in [7:0].
REQ-017 SHALL have port sen_cmd_vld, output, 1, one-cycle strobe: sen_* valid.

Function
REQ-018 SHALL accept frames: HEAD1, HEAD2, LEN_H, LEN_L, DEV_ID, SID, RW, data[0..LEN-4], CHK_H, CHK_L.
REQ-019 SHALL treat LEN as the 16-bit byte count from DEV_ID through the last data byte; payload length = LEN-3.
REQ-020 SHALL compute CHK as the 16-bit modulo sum of all bytes from LEN_H through the last data byte.
REQ-021 SHALL sample rx_data only in cycles where rx_flag=1; all other cycles SHALL leave state unchanged except the timeout counter.
REQ-022 SHALL use states WAIT, HEAD2, LEN_H, LEN_L, DEV, SID, RW, DATA, CHK_H, CHK_L, SKIP.
REQ-023 SHALL transition WAIT->HEAD2 on HEAD1; HEAD2->LEN_H on HEAD2, else ->HEAD2 if the byte is HEAD1, else ->WAIT.
REQ-024 SHALL check LEN after LEN_L: LEN<4 or LEN-3>MAX_DATA -> SKIP over LEN+2 bytes, then emit ERR_LEN (4'h2).
REQ-025 SHALL, on DEV_ID not equal to MY_ID and not 8'hFF, enter SKIP over the remaining LEN+1 bytes and emit nothing.
REQ-026 SHALL, on SID>=N_SEN, complete the frame, then emit ERR_SID (4'h3) with no sen_cmd_vld.
REQ-027 SHALL, on checksum mismatch, emit ERR_CRC (4'h1) with no sen_cmd_vld.
REQ-028 SHALL, on a valid frame, assert sen_cmd_vld and emit ACK_OK (4'h0) in the same cycle.
REQ-029 SHALL assert all strobes exactly one cycle, in the cycle after the rx_flag that delivers CHK_L (or the last SKIP byte).
REQ-030 SHALL hold ret_cmd and sen_* stable from their strobe until the next strobe; unused sen_data bytes SHALL be zero.
REQ-031 SHALL, for DEV_ID 8'hFF (broadcast), assert sen_cmd_vld on a valid frame but never ret_cmd_flg.
REQ-032 SHALL return to WAIT without any strobe when TIMEOUT_CYC clocks elapse with no rx_flag in any state other than WAIT.
REQ-033 SHALL restart the timeout counter on every rx_flag.
REQ-034 SHALL return to WAIT in the strobe cycle; an rx_flag in that same cycle SHALL be parsed from WAIT.

Reset
REQ-035 SHALL, while sys_rst=0, force state WAIT, clear counters and checksum, and drive all outputs to zero.
REQ-036 SHALL discard any partial frame on reset assertion mid-frame and produce no strobe after release.

Verification
REQ-037 SHALL pass: AA 55 00 05 01 02 01 12 34 00 4F -> sen_sel=4'b0100, sen_rw=1, sen_len=2, sen_data=32'h00003412, sen_cmd_vld and ret_cmd_flg with ret_cmd=0 one cycle after the last byte.
REQ-038 SHALL pass: the same frame with CHK_L=4E -> ret_cmd=4'h1 pulse, no sen_cmd_vld, sen_* unchanged.
REQ-039 SHALL pass: the same frame with DEV_ID=02 (CHK 00 50) -> no strobes, then the valid frame of REQ-037 parsed normally.
REQ-040 SHALL pass: AA 55 00 09 ... (payload 6 > MAX_DATA) followed by 11 bytes -> ret_cmd=4'h2 after the 11th byte.
REQ-041 SHALL pass: AA 55 00 05 01, then idle for TIMEOUT_CYC clocks -> no strobe; the next AA 55 frame is accepted.
REQ-042 SHALL pass: sys_rst pulsed low after byte 6 of REQ-037, then the remaining bytes sent -> no strobes, all outputs 0.
